// File: rtl/serneg_pkg.sv
// Shared types and constants for the serial negation controller.
// Optional per-word pass/negate select: SERNEG_PASS_SEL_EN.
package serneg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int W_DEF = 8;

  // Most-negative two's-complement pattern: 1 followed by w-1 zeros.
  function automatic logic [31:0] mneg_pat(int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/serneg_ctrl_if.sv
// Parallel word handshakes around the serial negation controller.
// SERNEG_PASS_SEL_EN adds the in_neg select.
interface serneg_ctrl_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
`ifdef SERNEG_PASS_SEL_EN
  logic         in_neg;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;

  modport master (
    output in_valid,
    output in_data,
`ifdef SERNEG_PASS_SEL_EN
    output in_neg,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef SERNEG_PASS_SEL_EN
    input  in_neg,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf
  );
endinterface

// File: rtl/serneg_bit_cell.sv
// Bit-serial two's-complement cell: pass bits until the first one,
// invert afterwards. SERNEG_PASS_SEL_EN adds force_pass.
module serneg_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
`ifdef SERNEG_PASS_SEL_EN
  input  logic force_pass,
`endif
  input  logic b,
  output logic y
);
  logic seen_q, seen_d;

  // Seen-one flag: cleared on word accept, set once a one passes.
  always_comb begin
    seen_d = seen_q;
    if (clr)
      seen_d = 1'b0;
    else if (en)
      seen_d = seen_q | b;
  end

  // Seen-one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seen_q <= 1'b0;
    else
      seen_q <= seen_d;
  end

`ifdef SERNEG_PASS_SEL_EN
  assign y = b ^ (seen_q & ~force_pass);
`else
  assign y = b ^ seen_q;
`endif

endmodule

// File: rtl/serneg_ctrl.sv
// Word-level sequencer for the bit-serial negation cell.
// SERNEG_PASS_SEL_EN enables per-word pass/negate via in_neg.
module serneg_ctrl
  import serneg_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic          t_clk,
  input  logic          r_n,
  serneg_ctrl_if.slave  io,
  output logic          busy
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [31:0] MNEG = mneg_pat(W);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  data_q, data_d;
  logic          cand_q, cand_d;
  logic          ovf_q, ovf_d;
  logic          cell_clr, cell_en, cell_y;
  logic          is_mneg;

  assign is_mneg = (io.in_data == MNEG[W-1:0]);

`ifdef SERNEG_PASS_SEL_EN
  logic pass_q, pass_d;
  logic cand_in;

  assign cand_in = is_mneg & io.in_neg;

  // Pass-mode select, latched with the operand.
  always_comb begin
    pass_d = pass_q;
    if (state_q == IDLE && io.in_valid)
      pass_d = ~io.in_neg;
  end

  // Pass-mode register.
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n)
      pass_q <= 1'b0;
    else
      pass_q <= pass_d;
  end
`else
  logic cand_in;

  assign cand_in = is_mneg;
`endif

  serneg_bit_cell u_cell (
    .clk        (t_clk),
    .rst_n      (r_n),
    .clr        (cell_clr),
    .en         (cell_en),
`ifdef SERNEG_PASS_SEL_EN
    .force_pass (pass_q),
`endif
    .b          (shift_q[0]),
    .y          (cell_y)
  );

  // Next state: accept, shift W bits, then hold result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    res_d    = res_q;
    data_d   = data_q;
    cand_d   = cand_q;
    ovf_d    = ovf_q;
    cell_clr = 1'b0;
    cell_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          shift_d  = io.in_data;
          res_d    = '0;
          cnt_d    = '0;
          cand_d   = cand_in;
          cell_clr = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        cell_en = 1'b1;
        res_d   = {cell_y, res_q[W-1:1]};
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          data_d  = {cell_y, res_q[W-1:1]};
          ovf_d   = cand_q;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      res_q   <= '0;
      data_q  <= '0;
      cand_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      res_q   <= res_d;
      data_q  <= data_d;
      cand_q  <= cand_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = data_q;
  assign io.out_ovf   = ovf_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_serneg_ctrl.sv
// Bench for serneg_ctrl (W=8): vector table, corner sequences and
// random words against a negation model.
module tb_serneg_ctrl;
  localparam int W = 8;

  logic t_clk = 1'b0;
  logic r_n   = 1'b0;
  logic busy;

  serneg_ctrl_if #(.W(W)) bus ();

  serneg_ctrl #(.W(W)) dut (
    .t_clk (t_clk),
    .r_n   (r_n),
    .io    (bus),
    .busy  (busy)
  );

  always #5 t_clk = ~t_clk;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [W-1:0] din;
    logic         neg;
    int           hold;
    bit           tog;
    logic [W-1:0] exp_d;
    logic         exp_ovf;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_neg(logic n);
`ifdef SERNEG_PASS_SEL_EN
    bus.in_neg = n;
`else
    if (n) begin end
`endif
  endtask

  // Model: negation is -x mod 2^W; pass mode returns x.
  function automatic logic [W-1:0] model_d(logic [W-1:0] x, logic n);
    int unsigned v;
    if (!n) return x;
    v = ((1 << W) - int'(x)) % (1 << W);
    return v[W-1:0];
  endfunction

  function automatic logic model_ovf(logic [W-1:0] x, logic n);
    return n && (int'(x) == (1 << (W - 1)));
  endfunction

  // One full word: accept, wait for result, hold, then handshake out.
  task automatic run_word(vec_t v, string tag);
    int n;
    @(negedge t_clk);
    chk({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v.din;
    drive_neg(v.neg);
    @(posedge t_clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      if (v.tog) begin
        bus.in_valid = n[0];
        bus.in_data  = 8'h55;
        if (n < W - 1)
          chk({tag, " in_ready shift"}, 32'(bus.in_ready), 32'd0);
      end
      @(posedge t_clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(W));
    chk({tag, " data"}, 32'(bus.out_data), 32'(v.exp_d));
    chk({tag, " ovf"}, 32'(bus.out_ovf), 32'(v.exp_ovf));
    for (int i = 0; i < v.hold; i++) begin
      @(posedge t_clk); #1;
      chk({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " hold data"}, 32'(bus.out_data), 32'(v.exp_d));
    end
    bus.out_ready = 1'b1;
    @(posedge t_clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " valid drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " ready back"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " data kept"}, 32'(bus.out_data), 32'(v.exp_d));
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int c, nacc;
    int acc[2];
    logic [W-1:0] x;
    logic         ng;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    drive_neg(1'b1);

    #12;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", 32'(bus.out_data), 32'd0);
    chk("rst out_ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge t_clk);
    r_n = 1'b1;

    tbl.push_back('{8'h01, 1'b1, 0, 1'b0, 8'hFF, 1'b0});
    tbl.push_back('{8'h6C, 1'b1, 0, 1'b0, 8'h94, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{8'hFF, 1'b1, 0, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{8'h80, 1'b1, 0, 1'b0, 8'h80, 1'b1});
    tbl.push_back('{8'h6C, 1'b1, 5, 1'b0, 8'h94, 1'b0});
    tbl.push_back('{8'h7F, 1'b1, 0, 1'b1, 8'h81, 1'b0});
`ifdef SERNEG_PASS_SEL_EN
    tbl.push_back('{8'h6C, 1'b0, 0, 1'b0, 8'h6C, 1'b0});
    tbl.push_back('{8'h80, 1'b0, 0, 1'b0, 8'h80, 1'b0});
`endif
    foreach (tbl[i])
      run_word(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back: in_valid held high, consumer always ready.
    @(negedge t_clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h01;
    bus.out_ready = 1'b1;
    nacc = 0;
    c = 0;
    while (nacc < 2 && c < 40) begin
      if (bus.in_ready) begin
        acc[nacc] = c;
        nacc++;
      end
      @(negedge t_clk);
      c++;
    end
    bus.in_valid = 1'b0;
    chk("b2b accepts", 32'(nacc), 32'd2);
    chk("b2b spacing", 32'(acc[1] - acc[0]), 32'(W + 2));
    c = 0;
    while (!bus.in_ready && c < 40) begin
      @(negedge t_clk);
      c++;
    end
    bus.out_ready = 1'b0;
    chk("b2b drained", 32'(bus.in_ready), 32'd1);

    // Reset in the 4th shift cycle of 0x6C.
    @(negedge t_clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h6C;
    @(posedge t_clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge t_clk);
    #1;
    chk("pre-rst busy", 32'(busy), 32'd1);
    r_n = 1'b0;
    #1;
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort out_data", 32'(bus.out_data), 32'd0);
    @(negedge t_clk);
    r_n = 1'b1;
    v = '{8'h01, 1'b1, 0, 1'b0, 8'hFF, 1'b0};
    run_word(v, "post-abort");

    // out_ready while idle is harmless.
    @(negedge t_clk);
    bus.out_ready = 1'b1;
    @(posedge t_clk); #1;
    bus.out_ready = 1'b0;
    chk("idle oready valid", 32'(bus.out_valid), 32'd0);
    chk("idle oready ready", 32'(bus.in_ready), 32'd1);

    // Random words against the model.
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom_range(0, (1 << W) - 1));
      if (i % 8 == 0) x = 8'h80;
`ifdef SERNEG_PASS_SEL_EN
      ng = 1'($urandom_range(0, 1));
`else
      ng = 1'b1;
`endif
      v.din     = x;
      v.neg     = ng;
      v.hold    = int'($urandom_range(0, 3));
      v.tog     = 1'($urandom_range(0, 1));
      v.exp_d   = model_d(x, ng);
      v.exp_ovf = model_ovf(x, ng);
      run_word(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serneg_ctrl.md
Name: serneg_ctrl

Overview:
- Word-level controller that sequences a bit-serial two's-complement cell.
- Accepts a parallel W-bit word over a valid/ready handshake and shifts it LSB-first through the serial cell, one bit per t_clk.
- Reassembles the serial result into a parallel word and presents it, with an overflow flag, on a valid/ready output.
- Sits between parallel producers/consumers and the serial complement datapath.

Parameters:
- W, 8: word width in bits; legal range 2..32.

Ports:
- t_clk  input  1  system clock; all state updates on rising edge.
- r_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word.
- in_data  input  W  two's-complement operand.
- out_valid  output  1  out_data/out_ovf hold a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  W  negated operand, i.e. (~in_data + 1) mod 2^W.
- out_ovf  output  1  operand was the most-negative value (1 followed by W-1 zeros); result equals operand.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (r_n low, async): state=IDLE, shift/result registers=0, bit counter=0, cell seen-one flag=0. Outputs: in_ready=1, out_valid=0, out_data=0, out_ovf=0, busy=0. Reset applies in any state, including mid-SHIFT; the partial word is discarded and is never output.
- FSM states:
  - IDLE: in_ready=1. On edge with in_valid=1: load operand into shift register, counter=0, clear cell flag, latch ovf_cand = (in_data == MSB-only pattern), go to SHIFT. With in_valid=0, stay in IDLE.
  - SHIFT: in_ready=0. Each edge:
    - cell input bit b = shift_reg[0]; cell output y = b XOR seen; seen <= seen OR b.
    - y shifts into result MSB; operand shifts right; counter increments.
    - When counter == W-1 at the edge (the W-th bit processed), go to DONE.
  - DONE: out_valid=1, out_data=result, out_ovf=ovf_cand. All outputs hold stable while out_ready=0. On edge with out_ready=1, go to IDLE; out_valid drops and out_data/out_ovf keep their last value.
- Latency: out_valid rises exactly W edges after the accepting edge.
- Throughput: in_ready exists only in IDLE, so one word per W+2 cycles minimum. There is no accept in the same cycle as the output handshake.
- in_valid during SHIFT/DONE is ignored; the producer must hold the word until in_ready.
- Edge values:
  - Operand 0: result 0, ovf=0.
  - Most-negative operand: result equals operand, ovf=1.
  - All-ones operand: result 1.
- out_ready high while out_valid is low has no effect.

Optional Feature:
- Macro SERNEG_PASS_SEL_EN.
- Defined: adds input port in_neg (1 bit), sampled with in_data on the accepting edge.
  - in_neg=0: the cell is forced to pass mode (y=b), the word is output unchanged, out_ovf=0. Latency is still W.
  - in_neg=1: normal negation.
- Undefined: no in_neg port; the block always negates.

Decomposition:
- Package serneg_pkg: FSM state enum (IDLE, SHIFT, DONE), default width constant, helper for the most-negative pattern of width W.
- One sub-module, serneg_bit_cell: seen-one flop with synchronous clear (asserted on the accept edge), async reset on r_n, combinational y = b XOR seen, and (under the macro) a force-pass input.
- The controller holds the FSM, counter, shift and result registers.

Test Plan (W=8):
- Reset, then in_data=0x01 with in_valid -> out_valid rises 8 edges after accept, out_data=0xFF, out_ovf=0.
- in_data=0x6C -> out_data=0x94; in_data=0x00 -> out_data=0x00, ovf=0; in_data=0xFF -> out_data=0x01.
- in_data=0x80 -> out_data=0x80, out_ovf=1.
- out_ready held low 5 cycles in DONE -> out_valid/out_data=0x94 stable; out_ready=1 -> IDLE next edge, in_ready=1. Back-to-back words are spaced 10 cycles apart.
- Pulse r_n low at the 4th SHIFT cycle of 0x6C -> in_ready=1, busy=0, out_valid=0 immediately. The next word 0x01 yields 0xFF, with no residue from the aborted word.
- In_valid toggling with 0x55 during SHIFT -> ignored, in_ready=0. With SERNEG_PASS_SEL_EN defined: in_neg=0, in_data=0x6C -> out_data=0x6C, ovf=0.
